pixel_row_serializer: RTL and testbench

//  Parametrised successor of the fixed 128-bit pixel shifter. Accepts one display row (WIDTH pixels)

---
 rtl/pixel_shifter_pkg.sv | 20 ++
 rtl/pixel_prescaler.sv | 33 +++
 rtl/pixel_row_serializer.sv | 121 ++++++++++++
 tb/tb_pixel_row_serializer.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/pixel_shifter_pkg.sv
// Shared types and width helpers for the pixel row serializer.
package pixel_shifter_pkg;

    // Serializer control state.
    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_ACTIVE = 1'b1
    } state_t;

    // Width of a counter that must hold 0..width inclusive.
    function automatic int bits_left_w(input int width);
        return $clog2(width + 1);
    endfunction

    // Width of the per-pixel repeat counter (0..scale-1), never narrower than 1 bit.
    function automatic int scale_cnt_w(input int scale);
        return (scale <= 1) ? 1 : $clog2(scale);
    endfunction

endpackage

// File: rtl/pixel_prescaler.sv
// Per-pixel repeat counter: holds each pixel for SCALE advance steps and
// raises tick on the advance step that completes the current pixel.
module pixel_prescaler
    import pixel_shifter_pkg::*;
#(
    parameter int SCALE = 1,
    parameter int SC_W  = scale_cnt_w(SCALE)
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic advance,
    output logic tick
);

    logic [SC_W-1:0] scale_cnt;
    logic            at_max;

    assign at_max = (scale_cnt == SC_W'(SCALE - 1));
    assign tick   = advance & at_max;

    // Count advance steps within one pixel; a new row restarts the count.
    always_ff @(posedge clock) begin
        if (reset) begin
            scale_cnt <= '0;
        end else if (clear) begin
            scale_cnt <= '0;
        end else if (advance) begin
            scale_cnt <= at_max ? '0 : scale_cnt + SC_W'(1);
        end
    end

endmodule

// File: rtl/pixel_row_serializer.sv
// Pixel row serializer: takes one display row through a valid/ready load
// handshake and emits it one pixel per completed advance step, with
// horizontal scaling, selectable bit order and end-of-row pulse.
// Build option: define PIXEL_ROW_ROTATE_EN to replay the loaded row
// continuously (scanline repeat) instead of returning to idle.
module pixel_row_serializer
    import pixel_shifter_pkg::*;
#(
    parameter int WIDTH     = 128,
    parameter int SCALE     = 1,
    parameter int MSB_FIRST = 1
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [WIDTH-1:0]              load_val,
    input  logic                          load_valid,
    output logic                          load_ready,
    input  logic                          shift,
    output logic                          pix_out,
    output logic                          pix_valid,
    output logic                          row_done,
    output logic [bits_left_w(WIDTH)-1:0] bits_left
);

    localparam int BL_W = bits_left_w(WIDTH);

`ifdef PIXEL_ROW_ROTATE_EN
    localparam bit ROTATE = 1'b1;
`else
    localparam bit ROTATE = 1'b0;
`endif

    state_t           state;
    state_t           state_nxt;
    logic [WIDTH-1:0] shreg;
    logic [WIDTH-1:0] shreg_adv;
    logic             active;
    logic             advance;
    logic             tick;
    logic             last_step;
    logic             accept;
    logic             emit_bit;
    logic             fill_bit;

    assign active    = (state == ST_ACTIVE);
    assign advance   = active & shift;
    assign last_step = tick & (bits_left == BL_W'(1));
    assign load_ready = ~active | last_step;
    assign accept    = load_valid & load_ready;

    assign emit_bit  = (MSB_FIRST != 0) ? shreg[WIDTH-1] : shreg[0];
    assign fill_bit  = ROTATE ? emit_bit : 1'b0;

    assign pix_out   = active & emit_bit;
    assign pix_valid = active;
    assign row_done  = last_step;

    pixel_prescaler #(
        .SCALE (SCALE)
    ) u_prescaler (
        .clock   (clock),
        .reset   (reset),
        .clear   (accept),
        .advance (advance),
        .tick    (tick)
    );

    // Shift register contents after one pixel advance toward the output end.
    always_comb begin
        shreg_adv = shreg;
        if (MSB_FIRST != 0) begin
            shreg_adv = {shreg[WIDTH-2:0], fill_bit};
        end else begin
            shreg_adv = {fill_bit, shreg[WIDTH-1:1]};
        end
    end

    // Next-state: a row accept always wins; end of row idles unless replaying.
    always_comb begin
        state_nxt = state;
        if (accept) begin
            state_nxt = ST_ACTIVE;
        end else if (last_step) begin
            state_nxt = ROTATE ? ST_ACTIVE : ST_IDLE;
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Row shift register: load on accept, advance once per completed pixel.
    always_ff @(posedge clock) begin
        if (reset) begin
            shreg <= '0;
        end else if (accept) begin
            shreg <= load_val;
        end else if (tick) begin
            shreg <= shreg_adv;
        end
    end

    // Remaining-pixel count, reloaded for a new row or a replayed pass.
    always_ff @(posedge clock) begin
        if (reset) begin
            bits_left <= '0;
        end else if (accept) begin
            bits_left <= BL_W'(WIDTH);
        end else if (last_step) begin
            bits_left <= ROTATE ? BL_W'(WIDTH) : '0;
        end else if (tick) begin
            bits_left <= bits_left - BL_W'(1);
        end
    end

endmodule

// File: tb/tb_pixel_row_serializer.sv
// Directed bench for pixel_row_serializer. Two instances: A (WIDTH=8,
// SCALE=1, MSB first) and B (WIDTH=8, SCALE=2, LSB first). Expectations
// for the end-of-row behaviour follow PIXEL_ROW_ROTATE_EN.
module tb_pixel_row_serializer;

    logic       clk;
    logic       rst;
    logic       shift;

    logic [7:0] a_val;
    logic       a_vld;
    logic       a_rdy;
    logic       a_pix;
    logic       a_pv;
    logic       a_done;
    logic [3:0] a_bl;

    logic [7:0] b_val;
    logic       b_vld;
    logic       b_rdy;
    logic       b_pix;
    logic       b_pv;
    logic       b_done;
    logic [3:0] b_bl;

    int n_chk;
    int n_bad;

    pixel_row_serializer #(.WIDTH(8), .SCALE(1), .MSB_FIRST(1)) u_dut_a (
        .clock      (clk),
        .reset      (rst),
        .load_val   (a_val),
        .load_valid (a_vld),
        .load_ready (a_rdy),
        .shift      (shift),
        .pix_out    (a_pix),
        .pix_valid  (a_pv),
        .row_done   (a_done),
        .bits_left  (a_bl)
    );

    pixel_row_serializer #(.WIDTH(8), .SCALE(2), .MSB_FIRST(0)) u_dut_b (
        .clock      (clk),
        .reset      (rst),
        .load_val   (b_val),
        .load_valid (b_vld),
        .load_ready (b_rdy),
        .shift      (shift),
        .pix_out    (b_pix),
        .pix_valid  (b_pv),
        .row_done   (b_done),
        .bits_left  (b_bl)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s act=%0d exp=%0d t=%0t", tag, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    int e2 [8]  = '{1, 0, 1, 1, 0, 0, 0, 1};
    int e3 [16] = '{1, 1, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0, 0, 1, 1};
    int e6 [8]  = '{1, 0, 1, 0, 0, 1, 0, 1};

    initial begin
        n_chk = 0;
        n_bad = 0;
        rst   = 1'b1;
        shift = 1'b1;
        a_val = '0;
        a_vld = 1'b0;
        b_val = '0;
        b_vld = 1'b0;
        step();
        step();
        rst = 1'b0;

        // 1: idle with shift held high
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("t1_pix", a_pix, 0);
            chk("t1_pv", a_pv, 0);
            chk("t1_rdy", a_rdy, 1);
            chk("t1_bl", int'(a_bl), 0);
            chk("t1_done", a_done, 0);
            chk("t1_b_pv", b_pv, 0);
            step();
        end

        // 2: SCALE=1, MSB first, row 8'b1011_0001
        a_val = 8'hB1;
        a_vld = 1'b1;
        @(negedge clk);
        chk("t2_rdy_idle", a_rdy, 1);
        chk("t2_pv_pre", a_pv, 0);
        step();
        a_vld = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk($sformatf("t2_pix%0d", k), a_pix, e2[k]);
            chk($sformatf("t2_pv%0d", k), a_pv, 1);
            chk($sformatf("t2_bl%0d", k), int'(a_bl), 8 - k);
            chk($sformatf("t2_done%0d", k), a_done, (k == 7) ? 1 : 0);
            chk($sformatf("t2_rdy%0d", k), a_rdy, (k == 7) ? 1 : 0);
            step();
        end
        @(negedge clk);
`ifdef PIXEL_ROW_ROTATE_EN
        chk("t2_end_pv", a_pv, 1);
        chk("t2_end_bl", int'(a_bl), 8);
        chk("t2_end_pix", a_pix, 1);
`else
        chk("t2_end_pv", a_pv, 0);
        chk("t2_end_bl", int'(a_bl), 0);
        chk("t2_end_rdy", a_rdy, 1);
        chk("t2_end_pix", a_pix, 0);
`endif
        do_reset();

        // 3: SCALE=2, LSB first, same row
        b_val = 8'hB1;
        b_vld = 1'b1;
        @(negedge clk);
        chk("t3_rdy_idle", b_rdy, 1);
        step();
        b_vld = 1'b0;
        for (int j = 0; j < 16; j++) begin
            @(negedge clk);
            chk($sformatf("t3_pix%0d", j), b_pix, e3[j]);
            chk($sformatf("t3_pv%0d", j), b_pv, 1);
            chk($sformatf("t3_bl%0d", j), int'(b_bl), 8 - j / 2);
            chk($sformatf("t3_done%0d", j), b_done, (j == 15) ? 1 : 0);
            step();
        end
        @(negedge clk);
`ifdef PIXEL_ROW_ROTATE_EN
        chk("t3_end_pv", b_pv, 1);
        chk("t3_end_bl", int'(b_bl), 8);
`else
        chk("t3_end_pv", b_pv, 0);
        chk("t3_end_bl", int'(b_bl), 0);
`endif
        do_reset();

        // 4: back-to-back rows FF then 00
        a_val = 8'hFF;
        a_vld = 1'b1;
        @(negedge clk);
        chk("t4_rdy_idle", a_rdy, 1);
        step();
        a_val = 8'h00;
        for (int k = 0; k < 16; k++) begin
            @(negedge clk);
            chk($sformatf("t4_pv%0d", k), a_pv, 1);
            chk($sformatf("t4_pix%0d", k), a_pix, (k < 8) ? 1 : 0);
            chk($sformatf("t4_rdy%0d", k), a_rdy, (k == 7 || k == 15) ? 1 : 0);
            chk($sformatf("t4_done%0d", k), a_done, (k == 7 || k == 15) ? 1 : 0);
            chk($sformatf("t4_bl%0d", k), int'(a_bl), 8 - (k % 8));
            step();
            if (k == 7) a_vld = 1'b0;
        end
        @(negedge clk);
`ifdef PIXEL_ROW_ROTATE_EN
        chk("t4_end_pv", a_pv, 1);
        chk("t4_end_pix", a_pix, 0);
`else
        chk("t4_end_pv", a_pv, 0);
`endif
        do_reset();

        // 5: reset mid-row, then reload with shift paused
        a_val = 8'hB1;
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_pix%0d", k), a_pix, e2[k]);
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        @(negedge clk);
        chk("t5_rst_pix", a_pix, 0);
        chk("t5_rst_pv", a_pv, 0);
        chk("t5_rst_bl", int'(a_bl), 0);
        chk("t5_rst_done", a_done, 0);
        chk("t5_rst_rdy", a_rdy, 1);
        shift = 1'b0;
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("t5_hold_pix%0d", k), a_pix, 1);
            chk($sformatf("t5_hold_bl%0d", k), int'(a_bl), 8);
            chk($sformatf("t5_hold_rdy%0d", k), a_rdy, 0);
            step();
        end
        shift = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk($sformatf("t5_re_pix%0d", k), a_pix, e2[k]);
            chk($sformatf("t5_re_bl%0d", k), int'(a_bl), 8 - k);
            step();
        end
        do_reset();

        // 6: row 8'hA5, three passes worth of cycles, no further load
        a_val = 8'hA5;
        a_vld = 1'b1;
        step();
        a_vld = 1'b0;
        for (int k = 0; k < 24; k++) begin
            @(negedge clk);
`ifdef PIXEL_ROW_ROTATE_EN
            chk($sformatf("t6_pix%0d", k), a_pix, e6[k % 8]);
            chk($sformatf("t6_pv%0d", k), a_pv, 1);
            chk($sformatf("t6_done%0d", k), a_done, (k % 8 == 7) ? 1 : 0);
            chk($sformatf("t6_bl%0d", k), int'(a_bl), 8 - (k % 8));
`else
            chk($sformatf("t6_pix%0d", k), a_pix, (k < 8) ? e6[k] : 0);
            chk($sformatf("t6_pv%0d", k), a_pv, (k < 8) ? 1 : 0);
            chk($sformatf("t6_done%0d", k), a_done, (k == 7) ? 1 : 0);
            chk($sformatf("t6_bl%0d", k), int'(a_bl), (k < 8) ? 8 - k : 0);
`endif
            step();
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
